// File: rtl/uart_mem_loader.sv
// uart_mem_loader: packs the UART receive byte stream into DATA_W-bit words and writes
// them with auto-incrementing byte addresses into one of N_TGT target memories. On
// leaving load mode a trailing partial word is zero-padded and flushed. After RUN_DELAY
// idle cycles, run is released to the core.
//
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous reset, active-high
//   load         in   1 = load mode, 0 = run mode (already synchronised)
//   sel          in   target memory for the next word (latched at the first byte)
//   rx_valid     in   uart_rx strobe; each rising edge delivers one byte
//   rx_data      in   received byte, stable when rx_valid rises
//   wr_en        out  one-hot write strobe, one cycle per word
//   wr_addr      out  byte address of the word's first byte
//   wr_data      out  assembled word
//   loaded_bytes out  bytes accepted in the current load session
//   run          out  core run enable
module uart_mem_loader #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned N_TGT      = 2,
  parameter int unsigned SEL_W      = 1,
  parameter int unsigned RUN_DELAY  = 100,
  parameter bit          BIG_ENDIAN = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [SEL_W-1:0]  sel,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic [N_TGT-1:0]  wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] loaded_bytes,
  output logic              run
);

  localparam int unsigned WB    = DATA_W / 8;
  localparam int unsigned IDX_W = (WB > 1) ? $clog2(WB) : 1;
  localparam int unsigned DLY_W = (RUN_DELAY > 0) ? $clog2(RUN_DELAY + 1) : 1;

  typedef enum logic [1:0] {S_WAIT, S_RUN, S_LOAD, S_FLUSH} state_e;

  state_e             state_q, state_d;
  logic [DLY_W-1:0]   delay_q, delay_d;
  logic               run_q, run_d;
  logic               rx_prev_q;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]  buf_q, buf_d;
  logic [SEL_W-1:0]   sel_lat_q, sel_lat_d;
  logic [ADDR_W-1:0]  addr_q [N_TGT];
  logic [ADDR_W-1:0]  addr_d [N_TGT];
  logic [N_TGT-1:0]   wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]  wr_data_q, wr_data_d;
  logic [ADDR_W-1:0]  loaded_q, loaded_d;

  logic               byte_acc;
  logic               enter_load;
  logic [SEL_W-1:0]   sel_eff;
  int unsigned        lane;
  logic [DATA_W-1:0]  buf_ins;
  logic               emit;
  logic [SEL_W-1:0]   emit_sel;
  logic [DATA_W-1:0]  emit_word;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_WAIT;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT: begin
        if (load)                 state_d = S_LOAD;
        else if (delay_q == '0)   state_d = S_RUN;
      end
      S_RUN:   if (load) state_d = S_LOAD;
      S_LOAD:  if (!load) state_d = (idx_q != '0) ? S_FLUSH : S_WAIT;
      S_FLUSH: state_d = S_WAIT;
      default: state_d = S_WAIT;
    endcase
  end

  // Byte strobe edge detect; bytes arriving outside load mode are ignored
  assign byte_acc   = rx_valid && !rx_prev_q && (state_q == S_LOAD) && load;
  assign enter_load = load && ((state_q == S_WAIT) || (state_q == S_RUN));
  // The first byte of a word picks the target; later sel changes wait for the next word
  assign sel_eff    = (idx_q == '0) ? sel : sel_lat_q;

  // Insert the incoming byte into its lane of the assembly buffer
  always_comb begin
    lane    = BIG_ENDIAN ? (WB - 1 - 32'(idx_q)) : 32'(idx_q);
    buf_ins = buf_q;
    buf_ins[lane*8 +: 8] = rx_data;
  end

  // Datapath and registered outputs
  always_comb begin
    delay_d   = delay_q;
    run_d     = run_q;
    idx_d     = idx_q;
    buf_d     = buf_q;
    sel_lat_d = sel_lat_q;
    for (int unsigned t = 0; t < N_TGT; t++) addr_d[t] = addr_q[t];
    wr_en_d   = '0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    loaded_d  = loaded_q;
    emit      = 1'b0;
    emit_sel  = sel_lat_q;
    emit_word = buf_q;

    case (state_q)
      S_WAIT: begin
        if (!load) begin
          if (delay_q == '0) run_d   = 1'b1;
          else               delay_d = delay_q - DLY_W'(1);
        end
      end
      S_LOAD: begin
        if (!load) begin
          if (idx_q == '0) delay_d = DLY_W'(RUN_DELAY);
        end else if (byte_acc) begin
          loaded_d  = loaded_q + ADDR_W'(1);
          sel_lat_d = sel_eff;
          if (idx_q == IDX_W'(WB - 1)) begin
            emit      = 1'b1;
            emit_sel  = sel_eff;
            emit_word = buf_ins;
            idx_d     = '0;
            buf_d     = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
            buf_d = buf_ins;
          end
        end
      end
      S_FLUSH: begin
        // Unfilled lanes are already zero because the buffer is cleared per word
        emit      = 1'b1;
        emit_sel  = sel_lat_q;
        emit_word = buf_q;
        idx_d     = '0;
        buf_d     = '0;
        delay_d   = DLY_W'(RUN_DELAY);
      end
      default: ;
    endcase

    // New load session starts from a clean slate and halts the core
    if (enter_load) begin
      for (int unsigned t = 0; t < N_TGT; t++) addr_d[t] = '0;
      idx_d    = '0;
      buf_d    = '0;
      loaded_d = '0;
      run_d    = 1'b0;
    end

    // Out-of-range targets match no t: word is dropped, counters untouched
    if (emit) begin
      for (int unsigned t = 0; t < N_TGT; t++) begin
        if (32'(emit_sel) == t) begin
          wr_en_d[t] = 1'b1;
          wr_addr_d  = addr_q[t];
          wr_data_d  = emit_word;
          addr_d[t]  = addr_q[t] + ADDR_W'(WB);
        end
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      delay_q   <= DLY_W'(RUN_DELAY);
      run_q     <= 1'b0;
      rx_prev_q <= 1'b0;
      idx_q     <= '0;
      buf_q     <= '0;
      sel_lat_q <= '0;
      for (int unsigned t = 0; t < N_TGT; t++) addr_q[t] <= '0;
      wr_en_q   <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      loaded_q  <= '0;
    end else begin
      delay_q   <= delay_d;
      run_q     <= run_d;
      rx_prev_q <= rx_valid;
      idx_q     <= idx_d;
      buf_q     <= buf_d;
      sel_lat_q <= sel_lat_d;
      for (int unsigned t = 0; t < N_TGT; t++) addr_q[t] <= addr_d[t];
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      loaded_q  <= loaded_d;
    end
  end

  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign loaded_bytes = loaded_q;
  assign run          = run_q;

endmodule
